// File: rtl/hwce_sop_sched_if.sv
// Handshake and status bundle between the HWCE tile controller, the streamer,
// the SOP array and the scheduler. "slave" is the scheduler side.
interface hwce_sop_sched_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] cfg_nb_pix;
    logic [CNT_WIDTH-1:0] cfg_nb_chan;
    logic                 cfg_precision8;
    logic                 x_valid;
    logic                 x_ready;
    logic                 sop_valid;
    logic                 sop_enable;
    logic                 sop_clear;
    logic [3:0]           sop_fsm_state;
    logic                 sop_precision8;
    logic                 sop_first_chan;
    logic                 sop_last_chan;
    logic                 sop_last_beat;
    logic                 y_valid;
    logic                 credit_ret;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, cfg_nb_pix, cfg_nb_chan, cfg_precision8,
        output x_valid, y_valid, credit_ret,
        input  x_ready, sop_valid, sop_enable, sop_clear, sop_fsm_state,
        input  sop_precision8, sop_first_chan, sop_last_chan, sop_last_beat,
        input  busy, done
    );

    modport slave (
        input  start, abort, cfg_nb_pix, cfg_nb_chan, cfg_precision8,
        input  x_valid, y_valid, credit_ret,
        output x_ready, sop_valid, sop_enable, sop_clear, sop_fsm_state,
        output sop_precision8, sop_first_chan, sop_last_chan, sop_last_beat,
        output busy, done
    );
endinterface

// File: rtl/hwce_sop_sched.sv
// SOP issue scheduler: walks one tile of nb_pix beats x nb_chan channels,
// tags beats for the accumulator and throttles issue against the result FIFO.
module hwce_sop_sched #(
    parameter int PIPE_STAGES = 14,
    parameter int CNT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    hwce_sop_sched_if.slave bus
);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int FLT_W  = $clog2(PIPE_STAGES + 2) + 1;

    localparam logic [CRED_W-1:0]    CRED_MAX = CRED_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0]    CRED_ONE = CRED_W'(1);
    localparam logic [FLT_W-1:0]     FLT_MAX  = FLT_W'(PIPE_STAGES + 1);
    localparam logic [FLT_W-1:0]     FLT_ONE  = FLT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0000,
        ST_LOAD  = 4'b0001,
        ST_RUN   = 4'b0011,
        ST_DRAIN = 4'b0110,
        ST_DONE  = 4'b1000
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] nb_pix_q, nb_pix_d;
    logic [CNT_WIDTH-1:0] nb_chan_q, nb_chan_d;
    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] chan_cnt_q, chan_cnt_d;
    logic                 prec_q, prec_d;
    logic                 abort_clr_q, abort_clr_d;
    logic [CRED_W-1:0]    credits_q, credits_d;
    logic [FLT_W-1:0]     in_flight_q, in_flight_d;

    logic aborting;
    logic x_ready;
    logic accept;
    logic pix_last;
    logic chan_first;
    logic chan_last;
    logic last_beat;
    logic cfg_empty;
    logic cred_inc, cred_dec;
    logic flt_inc, flt_dec;

    // Issue is withheld in the abort cycle so no beat enters a pipe about to be flushed.
    always_comb begin
        aborting   = bus.abort && (state_q != ST_IDLE);
        pix_last   = (pix_cnt_q == (nb_pix_q - CNT_ONE));
        chan_first = (chan_cnt_q == '0);
        chan_last  = (chan_cnt_q == (nb_chan_q - CNT_ONE));
        x_ready    = (state_q == ST_RUN) && !bus.abort && (credits_q < CRED_MAX);
        accept     = x_ready && bus.x_valid;
        last_beat  = accept && chan_last && pix_last;
        cfg_empty  = (bus.cfg_nb_pix == '0) || (bus.cfg_nb_chan == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = cfg_empty ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_flight_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (aborting) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        bus.x_ready        = x_ready;
        bus.sop_valid      = accept;
        bus.sop_enable     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        bus.sop_clear      = (state_q == ST_LOAD) || abort_clr_q;
        bus.sop_fsm_state  = state_q;
        bus.sop_precision8 = prec_q;
        bus.sop_first_chan = accept && chan_first;
        bus.sop_last_chan  = accept && chan_last;
        bus.sop_last_beat  = last_beat;
        bus.busy           = (state_q != ST_IDLE);
        bus.done           = (state_q == ST_DONE);
    end

    always_comb begin
        nb_pix_d    = nb_pix_q;
        nb_chan_d   = nb_chan_q;
        prec_d      = prec_q;
        pix_cnt_d   = pix_cnt_q;
        chan_cnt_d  = chan_cnt_q;
        credits_d   = credits_q;
        in_flight_d = in_flight_q;
        abort_clr_d = aborting;

        if ((state_q == ST_IDLE) && bus.start) begin
            nb_pix_d  = bus.cfg_nb_pix;
            nb_chan_d = bus.cfg_nb_chan;
            prec_d    = bus.cfg_precision8;
        end

        // Counters freeze on the final beat so the tags stay coherent through DRAIN.
        if (aborting || (state_q == ST_LOAD)) begin
            pix_cnt_d  = '0;
            chan_cnt_d = '0;
        end else if (accept && !last_beat) begin
            if (pix_last) begin
                pix_cnt_d  = '0;
                chan_cnt_d = chan_cnt_q + CNT_ONE;
            end else begin
                pix_cnt_d  = pix_cnt_q + CNT_ONE;
            end
        end

        // Only last-channel beats produce a FIFO entry, so only they consume credit.
        cred_inc = accept && chan_last;
        cred_dec = bus.credit_ret && (credits_q != '0);
        if (cred_inc && !cred_dec) begin
            credits_d = credits_q + CRED_ONE;
        end else if (!cred_inc && cred_dec) begin
            credits_d = credits_q - CRED_ONE;
        end

        flt_inc = accept;
        flt_dec = bus.y_valid && (in_flight_q != '0);
        if (aborting) begin
            in_flight_d = '0;
        end else if (flt_inc && !flt_dec) begin
            in_flight_d = in_flight_q + FLT_ONE;
        end else if (!flt_inc && flt_dec) begin
            in_flight_d = in_flight_q - FLT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nb_pix_q    <= '0;
            nb_chan_q   <= '0;
            prec_q      <= 1'b0;
            pix_cnt_q   <= '0;
            chan_cnt_q  <= '0;
            credits_q   <= '0;
            in_flight_q <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            nb_pix_q    <= nb_pix_d;
            nb_chan_q   <= nb_chan_d;
            prec_q      <= prec_d;
            pix_cnt_q   <= pix_cnt_d;
            chan_cnt_q  <= chan_cnt_d;
            credits_q   <= credits_d;
            in_flight_q <= in_flight_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    a_credit_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        bus.credit_ret |-> (credits_q != '0));
    a_result_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        bus.y_valid |-> (in_flight_q != '0));
    a_in_flight_bound : assert property (@(posedge clk) disable iff (!rst_n)
        in_flight_q <= FLT_MAX);

endmodule

// File: tb/tb_hwce_sop_sched.sv
// Randomized bench for hwce_sop_sched: a beat-index model of the tile predicts
// every output each cycle; directed tiles pin the model with literal counts.
module tb_hwce_sop_sched;
    localparam int P = 14;
    localparam int W = 16;
    localparam int D = 16;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 3, S_DRAIN = 6, S_DONE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hwce_sop_sched_if #(.CNT_WIDTH(W)) bus ();

    hwce_sop_sched #(
        .PIPE_STAGES(P),
        .CNT_WIDTH  (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: progress is tracked as a flat beat index.
    int   m_state = S_IDLE, m_beat = 0, m_npix = 0, m_nchan = 0, m_cred = 0, m_flight = 0;
    bit   m_prec = 1'b0, m_clr = 1'b0;
    logic [P-1:0] pipe = '0;

    int  xv_mode = 0, cr_mode = 0;
    bit  xv_tog = 1'b0, start_noise = 1'b0, chk_en = 1'b0;

    int n_acc = 0, n_first = 0, n_last = 0, n_lastb = 0, n_done = 0, n_clear = 0, n_y = 0;
    int n_prec0 = 0, n_prec1 = 0, y_at_done = 0;
    logic [3:0] last_fsm = 4'h0;
    logic [3:0] trace[$];
    logic [13:0] exp_v, act_v;

    function automatic logic [13:0] expect_vec();
        bit xr, acc;
        xr  = (m_state == S_RUN) && !bus.abort && (m_cred < D);
        acc = xr && bus.x_valid;
        return {xr, acc, (m_state == S_RUN) || (m_state == S_DRAIN),
                (m_state == S_LOAD) || m_clr, 4'(m_state), m_prec,
                acc && (m_beat < m_npix),
                acc && (m_beat >= (m_nchan - 1) * m_npix),
                acc && (m_beat == m_npix * m_nchan - 1),
                m_state != S_IDLE, m_state == S_DONE};
    endfunction

    function automatic logic [13:0] actual_vec();
        return {bus.x_ready, bus.sop_valid, bus.sop_enable, bus.sop_clear, bus.sop_fsm_state,
                bus.sop_precision8, bus.sop_first_chan, bus.sop_last_chan, bus.sop_last_beat,
                bus.busy, bus.done};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = expect_vec();
            act_v = actual_vec();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL outputs t=%0t act=%b exp=%b (xr,vld,en,clr,st[4],p8,fc,lc,lb,busy,done)",
                         $time, act_v, exp_v);
            end
            if (bus.sop_valid)      n_acc++;
            if (bus.sop_first_chan) n_first++;
            if (bus.sop_last_chan)  n_last++;
            if (bus.sop_last_beat)  n_lastb++;
            if (bus.sop_clear)      n_clear++;
            if (bus.y_valid)        n_y++;
            if (bus.done) begin
                n_done++;
                y_at_done = n_y;
            end
            if (bus.busy && !bus.sop_precision8) n_prec0++;
            if (bus.busy && bus.sop_precision8)  n_prec1++;
            if (bus.sop_fsm_state != last_fsm) begin
                trace.push_back(bus.sop_fsm_state);
                last_fsm = bus.sop_fsm_state;
            end
        end
    end

    task automatic model_update();
        bit acc, lc, lb, aborting;
        int old_flt, dc;
        if (!rst_n) begin
            m_state = S_IDLE; m_beat = 0; m_npix = 0; m_nchan = 0;
            m_cred = 0; m_flight = 0; m_prec = 1'b0; m_clr = 1'b0; pipe = '0;
            return;
        end
        acc = (m_state == S_RUN) && !bus.abort && (m_cred < D) && bus.x_valid;
        lc  = acc && (m_beat >= (m_nchan - 1) * m_npix);
        lb  = acc && (m_beat == m_npix * m_nchan - 1);
        aborting = bus.abort && (m_state != S_IDLE);
        old_flt = m_flight;
        dc = (lc ? 1 : 0) - ((bus.credit_ret && m_cred > 0) ? 1 : 0);
        m_cred += dc;
        if (aborting) m_flight = 0;
        else m_flight += (acc ? 1 : 0) - ((bus.y_valid && m_flight > 0) ? 1 : 0);
        pipe  = aborting ? '0 : {pipe[P-2:0], acc};
        m_clr = aborting;
        if (aborting) begin
            m_state = S_IDLE;
            m_beat  = 0;
        end else begin
            case (m_state)
                S_IDLE: if (bus.start) begin
                    m_npix  = int'(bus.cfg_nb_pix);
                    m_nchan = int'(bus.cfg_nb_chan);
                    m_prec  = bus.cfg_precision8;
                    m_state = (m_npix == 0 || m_nchan == 0) ? S_DONE : S_LOAD;
                end
                S_LOAD: begin
                    m_beat  = 0;
                    m_state = S_RUN;
                end
                S_RUN: if (acc) begin
                    if (lb) m_state = S_DRAIN;
                    else m_beat++;
                end
                S_DRAIN: if (old_flt == 0) m_state = S_DONE;
                S_DONE:  m_state = S_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        bus.y_valid = pipe[P-1];
        case (cr_mode)
            1:       bus.credit_ret = (m_cred > 0);
            2:       bus.credit_ret = (m_cred > 0) && ($urandom_range(0, 1) == 1);
            default: bus.credit_ret = 1'b0;
        endcase
        case (xv_mode)
            0: bus.x_valid = 1'b1;
            1: begin
                xv_tog = !xv_tog;
                bus.x_valid = xv_tog;
            end
            2:       bus.x_valid = ($urandom_range(0, 2) != 0);
            default: bus.x_valid = 1'b0;
        endcase
        bus.abort = 1'b0;
        bus.start = start_noise && (m_state != S_IDLE) && ($urandom_range(0, 3) == 0);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic start_tile(input int npix, input int nchan, input bit prec);
        bus.cfg_nb_pix     = W'(npix);
        bus.cfg_nb_chan    = W'(nchan);
        bus.cfg_precision8 = prec;
        bus.start          = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        int a0 = n_acc;
        while (m_state != S_IDLE && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (m_state != S_IDLE) begin
            failures++;
            $display("FAIL %s_timeout act=%0d exp=idle", name, m_state);
        end
        $display("tile %s npix=%0d nchan=%0d prec=%0d accepts=%0d cycles=%0d",
                 name, m_npix, m_nchan, m_prec, n_acc - a0, n);
    endtask

    task automatic drain_credits();
        int n = 0;
        cr_mode = 1;
        while (m_cred > 0 && n < 100) begin
            tick();
            n++;
        end
        check_int("credits_drained", m_cred, 0);
    endtask

    initial begin
        int a0, f0, l0, b0, d0, y0, c0, p0, k;
        int exp_tr[5] = '{1, 3, 6, 8, 0};

        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_nb_pix = '0; bus.cfg_nb_chan = '0;
        bus.cfg_precision8 = 1'b0; bus.x_valid = 1'b0; bus.y_valid = 1'b0; bus.credit_ret = 1'b0;
        xv_mode = 3;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check_int("reset_outputs", int'(actual_vec()), 0);

        // Tile 1: 4x3, streamer always ready, credits returned as fast as possible.
        xv_mode = 0; cr_mode = 1;
        a0 = n_acc; f0 = n_first; l0 = n_last; b0 = n_lastb; d0 = n_done; y0 = n_y;
        start_tile(4, 3, 0);
        wait_idle("t1", 200);
        tick();
        check_int("t1_accepts", n_acc - a0, 12);
        check_int("t1_first_chan", n_first - f0, 4);
        check_int("t1_last_chan", n_last - l0, 4);
        check_int("t1_last_beat", n_lastb - b0, 1);
        check_int("t1_done", n_done - d0, 1);
        check_int("t1_y_before_done", y_at_done - y0, 12);

        // Tile 2: credits exhausted after 16 results, then trickle 4 back.
        xv_mode = 0; cr_mode = 0;
        a0 = n_acc;
        start_tile(20, 1, 0);
        repeat (40) tick();
        check_int("t2_stall_accepts", n_acc - a0, 16);
        check_int("t2_x_ready_low", int'(bus.x_ready), 0);
        repeat (4) begin
            bus.credit_ret = 1'b1;
            tick();
            tick();
        end
        repeat (6) tick();
        check_int("t2_after_pulses", n_acc - a0, 20);
        wait_idle("t2", 100);
        drain_credits();

        // Tile 3: result-producing accept coincident with a credit return at 15.
        xv_mode = 0; cr_mode = 0;
        start_tile(17, 1, 0);
        k = 0;
        while (m_cred != 15 && k < 60) begin
            tick();
            k++;
        end
        bus.credit_ret = 1'b1;
        tick();
        check_int("t3_credits", m_cred, 15);
        check_int("t3_x_ready", int'(bus.x_ready), 1);
        cr_mode = 1;
        wait_idle("t3", 200);
        drain_credits();

        // Tile 4: abort after 5 accepts, then a clean restart.
        xv_mode = 0; cr_mode = 1;
        start_tile(4, 3, 0);
        k = 0;
        while (!(m_state == S_RUN && m_beat == 5) && k < 30) begin
            tick();
            k++;
        end
        d0 = n_done;
        bus.x_valid = 1'b0;
        bus.abort   = 1'b1;
        tick();
        check_int("t4_abort_state", int'(bus.sop_fsm_state), 0);
        check_int("t4_abort_clear", int'(bus.sop_clear), 1);
        check_int("t4_abort_busy", int'(bus.busy), 0);
        repeat (3) tick();
        check_int("t4_no_done", n_done - d0, 0);
        a0 = n_acc;
        start_tile(3, 2, 1);
        wait_idle("t4_restart", 200);
        tick();
        check_int("t4_restart_accepts", n_acc - a0, 6);

        // Tile 5: zero channels goes straight to DONE.
        a0 = n_acc; c0 = n_clear; d0 = n_done;
        start_tile(5, 0, 0);
        check_int("t5_state_done", int'(bus.sop_fsm_state), 8);
        check_int("t5_done_pulse", int'(bus.done), 1);
        repeat (3) tick();
        check_int("t5_no_valid", n_acc - a0, 0);
        check_int("t5_no_clear", n_clear - c0, 0);
        check_int("t5_one_done", n_done - d0, 1);

        // Tile 6: alternating x_valid in 8-bit mode, then reset in DRAIN.
        xv_mode = 1; cr_mode = 1;
        trace.delete();
        p0 = n_prec0;
        start_tile(3, 2, 1);
        wait_idle("t6", 200);
        tick();
        check_int("t6_trace_len", trace.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_int($sformatf("t6_trace_%0d", i), (i < trace.size()) ? int'(trace[i]) : -1, exp_tr[i]);
        end
        check_int("t6_prec8_held", n_prec0 - p0, 0);
        start_tile(3, 2, 1);
        k = 0;
        while (m_state != S_DRAIN && k < 40) begin
            tick();
            k++;
        end
        check_int("t6_reached_drain", m_state, S_DRAIN);
        rst_n = 1'b0;
        tick();
        check_int("t6_reset_outputs", int'(actual_vec()), 0);
        rst_n = 1'b1;
        tick();

        // Random tiles with random streamer/credit behaviour and occasional abort.
        for (int t = 0; t < 10; t++) begin
            xv_mode = 2; cr_mode = 2;
            start_noise = 1'b0;
            start_tile($urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            start_noise = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 15);
                repeat (k) if (m_state != S_IDLE) tick();
                if (m_state != S_IDLE) begin
                    bus.abort = 1'b1;
                    tick();
                end
            end
            wait_idle($sformatf("rand%0d", t), 2000);
            start_noise = 1'b0;
            bus.start   = 1'b0;
            tick();
        end
        drain_credits();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hwce_sop_sched.md
Name: hwce_sop_sched

Overview:
- Sequences the HWCE sum-of-products datapath over one convolution tile of cfg_nb_pix pixel beats × cfg_nb_chan input channels.
- Drives the SOP's enable, clear, fsm_state, precision8 and input valid, and tags each beat with first-channel, last-channel and last-beat flags.
- Credit-limits issue so results still in flight plus results not yet consumed never exceed the downstream output FIFO depth.
- Sits between the weight/line-buffer streamer and the SOP array.

Parameters:
PIPE_STAGES  14  SOP input-to-output latency in cycles; used only for drain accounting checks
CNT_WIDTH    16  width of the pixel and channel counters
FIFO_DEPTH   16  downstream result FIFO depth; the credit pool size

Ports:
clk             in   1          clock
rst_n           in   1          synchronous reset, active-low
start           in   1          begin a tile; sampled in IDLE only
abort           in   1          synchronous abort of the current tile
cfg_nb_pix      in   CNT_WIDTH  pixel beats per channel
cfg_nb_chan     in   CNT_WIDTH  input channels
cfg_precision8  in   1          8-bit packed mode
x_valid         in   1          streamer has pixels and weights for the current beat
x_ready         out  1          beat accepted this cycle when x_valid is also high
sop_valid       out  1          valid to the SOP input
sop_enable      out  1          SOP pipeline advance
sop_clear       out  1          SOP pipeline flush
sop_fsm_state   out  4          state code to the SOP
sop_precision8  out  1          latched cfg_precision8
sop_first_chan  out  1          beat belongs to channel 0 (overwrite accumulator)
sop_last_chan   out  1          beat belongs to the last channel (emit result)
sop_last_beat   out  1          final beat of the tile
y_valid         in   1          SOP output valid
credit_ret      in   1          downstream popped one result
busy            out  1          state is not IDLE
done            out  1          one-cycle pulse at tile end

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, in_flight and credits 0.
- State codes: IDLE=4'b0000, LOAD=4'b0001, RUN=4'b0011, DRAIN=4'b0110, DONE=4'b1000. sop_fsm_state equals the current state code.
- IDLE:
  - On start, latch cfg_*, then go to LOAD.
  - If cfg_nb_pix==0 or cfg_nb_chan==0, go straight to DONE instead.
  - start is ignored outside IDLE.
- LOAD: sop_clear=1 for exactly one cycle; pix_cnt and chan_cnt set to 0; next state RUN.
- RUN handshake:
  - x_ready = (credits_used < FIFO_DEPTH).
  - Accept = x_valid & x_ready; sop_valid = accept (combinational).
  - sop_first_chan = (chan_cnt==0); sop_last_chan = (chan_cnt==nb_chan-1); sop_last_beat = last_chan & (pix_cnt==nb_pix-1). All three are qualified by accept.
- Counters on accept:
  - pix_cnt increments and wraps to 0 at nb_pix-1; on wrap, chan_cnt increments.
  - On the last beat, go to DRAIN; counters hold.
- Credits:
  - credits_used increments on an accept that has last_chan=1 (only those beats produce results).
  - credits_used decrements on credit_ret.
  - Simultaneous increment and decrement leaves it unchanged.
  - credit_ret at credits_used==0 is ignored; assertion error in simulation.
- In-flight tracking:
  - in_flight increments on any accept and decrements on y_valid. Simultaneous events leave it unchanged.
  - y_valid at in_flight==0 is ignored; assertion.
  - Assertion: in_flight ≤ PIPE_STAGES+1.
- sop_enable = 1 in RUN and DRAIN, 0 otherwise. The SOP is never stalled mid-pipe; backpressure is applied only by withholding issue.
- DRAIN: x_ready=0; when in_flight==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. Credits are not required to be 0; busy deasserts in IDLE.
- abort in any non-IDLE state:
  - Next cycle the state is IDLE and sop_clear=1 for one cycle; in_flight and the counters reset.
  - credits_used is kept, since results already in the FIFO still return credits.
  - done is not pulsed.
- Priority: rst_n > abort > normal transitions.
- Width rules: counters compare against cfg-1 in CNT_WIDTH. Comparison is unsigned.

Test Plan:
1. nb_pix=4, nb_chan=3, x_valid always 1, credit_ret tied high.
   - 12 accepts on consecutive cycles; first_chan on beats 0-3; last_chan on beats 8-11; last_beat on beat 11 only.
   - done pulses once, after 12 y_valid returns.
2. FIFO_DEPTH=16, nb_pix=20, nb_chan=1, credit_ret=0.
   - x_ready drops after 16 accepts.
   - Pulsing credit_ret 4 times lets exactly 4 more beats in; the tile completes.
3. Simultaneous accept with last_chan and credit_ret at credits_used=16-1 → credits_used stays 15 and x_ready stays 1.
4. abort asserted in RUN after 5 accepts.
   - Next cycle: IDLE, sop_clear=1, busy=0, no done pulse.
   - A following start with new cfg runs cleanly.
5. cfg_nb_chan=0 with start → DONE the next cycle; done pulses; no sop_valid and no sop_clear.
6. x_valid toggling 1010…, nb_pix=3, nb_chan=2, precision8=1.
   - sop_precision8=1 throughout.
   - sop_fsm_state sequence: 0001, 0011, 0110, 1000, 0000.
   - rst_n low in DRAIN → all outputs 0 the next cycle.
